// File: rtl/router_out_fifo.sv
// router_out_fifo: per-port output FIFO with header tagging, packet-end tracking and read-timeout flush
module router_out_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lfd_state,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              soft_reset
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [5:0]      pkt_cnt;
    logic [TW-1:0]   to_cnt;
    logic [DATA_W:0] rd_word;
    logic            wr_acc, rd_acc;

    always_comb begin
        empty     = wr_ptr == rd_ptr;
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        valid_out = ~empty;
        wr_acc    = write_enb && !full;
        rd_acc    = read_enb && !empty;
        rd_word   = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (wr_acc && !reset && !soft_reset)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            to_cnt     <= '0;
            soft_reset <= 1'b0;
            data_out   <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) begin
                data_out <= rd_word[DATA_W-1:0];
                rd_ptr   <= rd_ptr + PW'(1);
                pkt_cnt  <= rd_word[DATA_W] ? rd_word[7:2] + 6'd1 :
                            (pkt_cnt == 6'd0) ? 6'd0 : pkt_cnt - 6'd1;
            end else if (pkt_cnt == 6'd0) begin
                data_out <= '0;
            end
            to_cnt     <= (read_enb || empty) ? '0 : to_cnt + TW'(1);
            soft_reset <= !read_enb && !empty && (to_cnt == TW'(TIMEOUT - 1));
        end
    end
endmodule

// File: tb/tb_router_out_fifo.sv
// tb_router_out_fifo: directed stimulus with a write-order scoreboard and a decoupled read monitor
module tb_router_out_fifo;
    logic       clock = 0;
    logic       reset = 1;
    logic       write_enb = 0;
    logic [7:0] data_in = 0;
    logic       lfd_state = 0;
    logic       read_enb = 0;
    logic [7:0] data_out;
    logic       valid_out, full, empty, soft_reset;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic pend = 0;

    router_out_fifo dut (
        .clock(clock), .reset(reset), .write_enb(write_enb), .data_in(data_in),
        .lfd_state(lfd_state), .read_enb(read_enb), .data_out(data_out),
        .valid_out(valid_out), .full(full), .empty(empty), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clock) begin
        if (pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got %0h with nothing expected", data_out);
            end else begin
                chk("sb_data", {24'd0, data_out}, {24'd0, sb.pop_front()});
            end
        end
        pend = read_enb && valid_out && !reset && !soft_reset;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic hdr, input logic push);
        write_enb = 1; data_in = d; lfd_state = hdr;
        tick();
        write_enb = 0; lfd_state = 0;
        if (push) sb.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pkt [5];
        pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h3C};
        tick(); tick();
        chk("rst_empty", empty, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_full", full, 0);
        chk("rst_data", data_out, 0);
        chk("rst_soft", soft_reset, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 5; i++) wr(pkt[i], i == 0, 1);
        read_enb = 1;
        repeat (5) tick();
        read_enb = 0;
        tick();
        chk("pkt_end_data", data_out, 0);
        chk("pkt_end_valid", valid_out, 0);

        for (int i = 0; i < 17; i++) begin
            wr(8'(i), 0, i < 16);
            if (i == 15) chk("full_at_16", full, 1);
        end
        chk("full_after_17", full, 1);
        read_enb = 1;
        repeat (16) tick();
        chk("drained_empty", empty, 1);
        tick();
        chk("read_empty_data", data_out, 0);
        read_enb = 0;
        tick();

        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 0, 1);
        write_enb = 1; read_enb = 1;
        for (int j = 0; j < 32; j++) begin
            data_in = 8'h88 + 8'(j);
            tick();
            sb.push_back(8'h88 + 8'(j));
            chk("wrap_flags", {full, empty}, 0);
        end
        write_enb = 0;
        repeat (8) tick();
        chk("wrap_empty", empty, 1);
        read_enb = 0;
        tick();

        wr(8'h55, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) begin
                write_enb = 1; data_in = 8'h77;
            end
            tick();
            chk("to_pulse", soft_reset, k == 30);
        end
        tick();
        write_enb = 0;
        chk("to_after_soft", soft_reset, 0);
        chk("to_flush_empty", empty, 1);
        chk("to_flush_data", data_out, 0);

        wr(8'h66, 0, 1);
        for (int k = 1; k <= 40; k++) begin
            read_enb = (k == 20);
            tick();
            chk("no_timeout", soft_reset, 0);
        end
        read_enb = 0;
        chk("pulse_empty", empty, 1);

        wr(8'h10, 1, 1);
        for (int i = 1; i < 5; i++) wr(8'hA0 + 8'(i), 0, 1);
        read_enb = 1;
        tick(); tick();
        reset = 1;
        tick();
        sb.delete();
        chk("midrst_empty", empty, 1);
        chk("midrst_data", data_out, 0);
        reset = 0; read_enb = 0;
        tick();
        wr(8'h08, 1, 1);
        wr(8'hB1, 0, 1);
        wr(8'hB2, 0, 1);
        wr(8'h0A, 0, 1);
        read_enb = 1;
        repeat (4) tick();
        read_enb = 0;
        tick();
        chk("post_rst_end", data_out, 0);
        @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_out_fifo.md
# router_out_fifo

Per-port output buffer of the 1x3 router, sitting between the router's write-side control and one destination port. It stores packet bytes written by the router core, tags header bytes, and presents them on the destination interface as `data_out`/`valid_out`, with the destination pulling bytes via `read_enb`. It also tracks packet boundaries and runs a read-timeout watchdog that flushes the buffer with a `soft_reset` pulse if the destination does not start reading in time.

## Interface
- `DATA_W`, 8: byte width.
- `DEPTH`, 16: entries; must be a power of two.
- `TIMEOUT`, 30: consecutive cycles of `valid_out=1` with `read_enb=0` before a flush.

- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_enb`  in  1  write request from router core.
- `data_in`  in  DATA_W  byte to write.
- `lfd_state`  in  1  high with `write_enb` marks `data_in` as a header byte.
- `read_enb`  in  1  read request from destination.
- `data_out`  out  DATA_W  registered read data.
- `valid_out`  out  1  buffer non-empty (`~empty`).
- `full`  out  1  DEPTH entries held.
- `empty`  out  1  zero entries held.
- `soft_reset`  out  1  one-cycle pulse when the timeout fires.

## Operation
- Storage: DEPTH x (DATA_W+1); bit DATA_W is the header flag, written from `lfd_state`.
- Pointers: `wr_ptr`/`rd_ptr` are log2(DEPTH)+1 bits.
  - `empty` when pointers are equal.
  - `full` when MSBs differ and the low bits are equal.
  - Wrap is natural modulo 2*DEPTH.
- Write: accepted iff `write_enb && !full`, with `full` evaluated before any same-cycle read. A write while full is dropped; pointer and contents are unchanged.
- Read: accepted iff `read_enb && !empty`. `data_out <= mem[rd_ptr][DATA_W-1:0]` and `rd_ptr` increments.
- Read while empty: ignored. `data_out` follows the packet-end rule below.
- Simultaneous accepted read and write: both happen; occupancy is unchanged.
- Packet counter `pkt_cnt` (6 bits):
  - On an accepted read of a header entry, load `data[7:2] + 1` (payload length plus parity byte).
  - On an accepted read of a non-header entry, decrement, saturating at 0.
- Packet end: when no read is accepted in a cycle and `pkt_cnt == 0`, `data_out <= 0`. Otherwise `data_out` holds its value.
- Watchdog `to_cnt`:
  - Increments each cycle with `valid_out && !read_enb`.
  - Clears when `read_enb` is high or the buffer is empty.
  - When it would reach TIMEOUT, `soft_reset` is 1 for exactly that next cycle.
- Flush: in the cycle `soft_reset` asserts, pointers, `pkt_cnt` and `to_cnt` clear and `data_out <= 0`.
  - A write presented in the flush-trigger cycle is discarded.
- Priority: `reset` > flush > normal read/write.

## Timing
- Reset values: `data_out=0`, `valid_out=0`, `empty=1`, `full=0`, `soft_reset=0`. Pointers, `pkt_cnt` and `to_cnt` are also 0.
- `empty`, `full` and `valid_out` are combinational from the pointers. They update the cycle after the pointer-changing edge.
- Write-to-visible latency: data written at edge N gives `valid_out=1` after edge N. The earliest read is accepted at edge N+1, with data on `data_out` after edge N+1.
- Read latency: 1 cycle. `read_enb` sampled high at edge N gives the byte on `data_out` after edge N.
- Back-to-back reads sustain 1 byte per cycle. Back-to-back writes sustain 1 byte per cycle until full.
- Watchdog: with `valid_out` rising after edge N and `read_enb` held low, `soft_reset` is high after edge N+TIMEOUT. The buffer is empty after edge N+TIMEOUT+1.
- Reset mid-packet or mid-countdown takes effect at the next edge and overrides everything; no partial state survives.

## Test plan
- Reset: hold `reset` for 2 cycles → `empty=1`, `valid_out=0`, `full=0`, `data_out=0x00`, `soft_reset=0`.
- Single packet: write header 0x0C (payload length 3, `lfd_state=1`), then 0x11, 0x22, 0x33 and parity 0x3C; assert `read_enb` 5 cycles → `data_out` shows 0x0C, 0x11, 0x22, 0x33, 0x3C on consecutive cycles, then 0x00 with `valid_out=0`.
- Full/overflow: write 17 bytes 0x00..0x10 without reading → `full=1` after the 16th write and the 17th is dropped; 16 reads return 0x00..0x0F, then `empty=1`.
- Wrap with simultaneous read and write: keep occupancy at 8 while streaming 40 bytes → output order matches input, `full` and `empty` never assert, pointers wrap correctly.
- Timeout: write 1 byte and hold `read_enb=0` → `soft_reset` pulses exactly 30 cycles after `valid_out` rises, then `empty=1`.
  - Repeat with one `read_enb` pulse at cycle 20 → no `soft_reset`.
- Mid-operation reset: assert `reset` during a 5-byte read burst → the next cycle shows `empty=1` and `data_out=0x00`; a new packet afterwards reads correctly.
